// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the PC generator and its return-address stack.
package pc_gen_pkg;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [2:0]  STEP_HALF          = 3'd2;
    localparam logic [2:0]  STEP_FULL          = 3'd4;
    localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Instantiated by pc_gen only when PC_GEN_RAS_EN is defined.
module pc_ras
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    output logic [ADDR_W-1:0] top_o,
    output logic              empty_o
);

    localparam int unsigned    PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] FULL  = (PTR_W + 1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count_q;

    // Pop+push replaces the top in place, so the write slot stays on the current top.
    assign wr_ptr  = pop_i ? ptr_q : ptr_q + 1'b1;
    assign top_o   = mem[ptr_q];
    assign empty_o = (count_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else if (push_i) begin
            ptr_q <= wr_ptr;
            if (!pop_i && count_q != FULL) begin
                count_q <= count_q + 1'b1;
            end
        end else if (pop_i) begin
            ptr_q   <= ptr_q - 1'b1;
            count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) begin
            mem[wr_ptr] <= push_addr_i;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: boot/run sequencing, prioritised redirects and sequential stepping.
// Return-address-stack prediction is built only when PC_GEN_RAS_EN is defined.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(DEFAULT_RESET_ADDR),
    parameter int unsigned       NUM_REDIR  = 2,
    parameter int unsigned       RAS_DEPTH  = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             soft_rst_i,
    input  logic [NUM_REDIR-1:0]             redir_valid_i,
    input  logic [NUM_REDIR-1:0][ADDR_W-1:0] redir_addr_i,
    input  logic                             hold_i,
    input  logic                             fetch_ready_i,
    input  logic                             step2_i,
    input  logic                             call_i,
    input  logic                             ret_i,
    output logic [ADDR_W-1:0]                pc_o,
    output logic                             pc_valid_o,
    output logic                             redir_taken_o,
    output logic                             ras_empty_o,
    output logic                             ras_miss_o
);

    localparam logic [ADDR_W-1:0] EVEN_MASK = ~ADDR_W'(1);
    localparam logic [ADDR_W-1:0] RESET_PC  = RESET_ADDR & EVEN_MASK;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] redir_addr;
    logic [ADDR_W-1:0] ras_top;
    logic              redir_any;
    logic              advance;
    logic              ras_empty;
    logic              ras_hit;
    logic              miss_d;
    logic              redir_taken_q;
    logic              ras_miss_q;

    assign pc_valid_o = (state_q == ST_RUN);
    assign advance    = pc_valid_o && fetch_ready_i && !hold_i;
    assign step       = ADDR_W'(step2_i ? STEP_HALF : STEP_FULL);
    assign ras_hit    = advance && ret_i && !ras_empty;

    always_comb begin
        redir_any  = 1'b0;
        redir_addr = '0;
        for (int unsigned i = 0; i < NUM_REDIR; i++) begin
            if (redir_valid_i[i] && !redir_any) begin
                redir_any  = 1'b1;
                redir_addr = redir_addr_i[i];
            end
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (soft_rst_i) begin
            pc_d = RESET_PC;
        end else if (redir_any) begin
            pc_d = redir_addr & EVEN_MASK;
        end else if (ras_hit) begin
            pc_d = ras_top & EVEN_MASK;
        end else if (advance) begin
            pc_d = pc_q + step;
        end
    end

`ifdef PC_GEN_RAS_EN
    logic ras_quiet;
    logic ras_push;
    logic ras_pop;

    // A redirect or soft reset overrides the fetch, so its call/return hints must not touch the stack.
    assign ras_quiet = soft_rst_i || redir_any;
    assign ras_push  = advance && call_i && !ras_quiet;
    assign ras_pop   = ras_hit && !ras_quiet;
    assign miss_d    = advance && ret_i && ras_empty && !ras_quiet;

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (soft_rst_i),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_addr_i (pc_q + step),
        .top_o       (ras_top),
        .empty_o     (ras_empty)
    );
`else
    logic unused_call;

    assign unused_call = call_i;
    assign ras_top     = '0;
    assign ras_empty   = 1'b1;
    assign miss_d      = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            redir_taken_q <= 1'b0;
            ras_miss_q    <= 1'b0;
        end else begin
            state_q       <= soft_rst_i ? ST_BOOT : ST_RUN;
            pc_q          <= pc_d;
            redir_taken_q <= redir_any && !soft_rst_i;
            ras_miss_q    <= miss_d;
        end
    end

    assign pc_o          = pc_q;
    assign redir_taken_o = redir_taken_q;
    assign ras_empty_o   = ras_empty;
    assign ras_miss_o    = ras_miss_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic against a queue-based model.
// Expectations follow PC_GEN_RAS_EN, so the bench works with the stack built in or left out.
module tb_pc_gen;

`ifdef PC_GEN_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif
    localparam int          DEPTH = 4;
    localparam logic [31:0] RST_A = 32'h100;

    logic            clk = 1'b0;
    logic            rst;
    logic            soft_rst;
    logic [1:0]      redir_valid;
    logic [1:0][31:0] redir_addr;
    logic            hold;
    logic            fetch_ready;
    logic            step2;
    logic            call;
    logic            ret;
    logic [31:0]     pc;
    logic            pc_valid;
    logic            redir_taken;
    logic            ras_empty;
    logic            ras_miss;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_taken;
    logic        m_miss;
    logic [31:0] m_ras[$];

    pc_gen #(
        .ADDR_W     (32),
        .RESET_ADDR (32'h100),
        .NUM_REDIR  (2),
        .RAS_DEPTH  (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .soft_rst_i    (soft_rst),
        .redir_valid_i (redir_valid),
        .redir_addr_i  (redir_addr),
        .hold_i        (hold),
        .fetch_ready_i (fetch_ready),
        .step2_i       (step2),
        .call_i        (call),
        .ret_i         (ret),
        .pc_o          (pc),
        .pc_valid_o    (pc_valid),
        .redir_taken_o (redir_taken),
        .ras_empty_o   (ras_empty),
        .ras_miss_o    (ras_miss)
    );

    always #5 clk = ~clk;

    function automatic logic m_empty();
        return RAS_EN ? (m_ras.size() == 0) : 1'b1;
    endfunction

    task automatic model_reset();
        m_pc    = RST_A;
        m_valid = 1'b0;
        m_taken = 1'b0;
        m_miss  = 1'b0;
        m_ras.delete();
    endtask

    // Advance the model by one clock with the currently driven inputs, then step the DUT.
    task automatic tick();
        logic [31:0] stp;
        logic [31:0] nxt;
        logic        ntaken;
        logic        nmiss;
        logic        nvalid;
        logic        adv;
        stp    = step2 ? 32'd2 : 32'd4;
        adv    = m_valid && fetch_ready && !hold;
        nxt    = m_pc;
        ntaken = 1'b0;
        nmiss  = 1'b0;
        nvalid = 1'b1;
        if (soft_rst) begin
            nxt    = RST_A;
            nvalid = 1'b0;
            m_ras.delete();
        end else if (redir_valid != 2'b00) begin
            nxt    = (redir_valid[0] ? redir_addr[0] : redir_addr[1]) & ~32'd1;
            ntaken = 1'b1;
        end else if (adv) begin
            if (RAS_EN && ret && m_ras.size() != 0) begin
                nxt = m_ras[$];
                void'(m_ras.pop_back());
            end else begin
                nxt = m_pc + stp;
                nmiss = RAS_EN && ret;
            end
            if (RAS_EN && call) begin
                m_ras.push_back(m_pc + stp);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
        end
        @(posedge clk);
        m_pc    = nxt;
        m_valid = nvalid;
        m_taken = ntaken;
        m_miss  = nmiss;
        #1;
    endtask

    task automatic idle_inputs();
        soft_rst    = 1'b0;
        redir_valid = 2'b00;
        redir_addr  = '0;
        hold        = 1'b0;
        fetch_ready = 1'b1;
        step2       = 1'b0;
        call        = 1'b0;
        ret         = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        redir_valid   = 2'b01;
        redir_addr[0] = a;
        tick();
        redir_valid   = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pc !== RST_A) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, RST_A); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pc_valid); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", ras_empty); end
        checks++; if (redir_taken !== 1'b0 || ras_miss !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: got taken=%b miss=%b expected 0/0", redir_taken, ras_miss);
        end
        rst = 1'b0;
        #1;
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b expected 0", pc_valid); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h100;
        exp_pc[1] = 32'h104;
        exp_pc[2] = 32'h108;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== exp_pc[i] || pc_valid !== 1'b1) begin
                errors++; $display("FAIL seq_%0d: got pc=%h valid=%b expected pc=%h valid=1", i, pc, pc_valid, exp_pc[i]);
            end
        end
    endtask

    task automatic test_redirect();
        hold          = 1'b1;
        redir_valid   = 2'b11;
        redir_addr[0] = 32'h200;
        redir_addr[1] = 32'h300;
        tick();
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL redir_prio: got %h expected 00000200", pc); end
        checks++; if (redir_taken !== 1'b1) begin errors++; $display("FAIL redir_taken: got %b expected 1", redir_taken); end
        redir_valid   = 2'b10;
        redir_addr[1] = 32'h301;
        tick();
        checks++; if (pc !== 32'h300) begin errors++; $display("FAIL redir_lsb: got %h expected 00000300", pc); end
        redir_valid = 2'b00;
        tick();
        checks++; if (pc !== 32'h300 || redir_taken !== 1'b0) begin
            errors++; $display("FAIL redir_hold: got pc=%h taken=%b expected 00000300/0", pc, redir_taken);
        end
        hold = 1'b0;
    endtask

    task automatic test_step();
        redirect_to(32'h10);
        step2 = 1'b1;
        tick();
        checks++; if (pc !== 32'h12) begin errors++; $display("FAIL step2: got %h expected 00000012", pc); end
        step2 = 1'b0;
        redirect_to(32'hFFFF_FFFC);
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap: got %h expected 00000000", pc); end
    endtask

    task automatic test_ras_call_ret();
        redirect_to(32'h40);
        call = 1'b1;
        tick();
        call = 1'b0;
        checks++; if (ras_empty !== !RAS_EN) begin errors++; $display("FAIL call_push: got empty=%b expected %b", ras_empty, !RAS_EN); end
        redirect_to(32'h80);
        ret = 1'b1;
        tick();
        ret = 1'b0;
        checks++; if (pc !== (RAS_EN ? 32'h44 : 32'h84)) begin
            errors++; $display("FAIL ret_target: got %h expected %h", pc, RAS_EN ? 32'h44 : 32'h84);
        end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ret_empty: got %b expected 1", ras_empty); end
    endtask

    task automatic test_ras_overflow();
        redirect_to(32'h1000);
        call = 1'b1;
        repeat (DEPTH + 1) tick();
        call = 1'b0;
        ret  = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            tick();
            checks++; if (pc !== m_pc || ras_miss !== m_miss) begin
                errors++; $display("FAIL ovf_ret_%0d: got pc=%h miss=%b expected pc=%h miss=%b", i, pc, ras_miss, m_pc, m_miss);
            end
        end
        ret = 1'b0;
        checks++; if (pc !== (RAS_EN ? 32'h100C : 32'h1028) || ras_miss !== RAS_EN) begin
            errors++; $display("FAIL ovf_last: got pc=%h miss=%b expected pc=%h miss=%b",
                               pc, ras_miss, RAS_EN ? 32'h100C : 32'h1028, RAS_EN);
        end
        tick();
        checks++; if (ras_miss !== 1'b0) begin errors++; $display("FAIL miss_pulse: got %b expected 0", ras_miss); end
    endtask

    task automatic test_soft_reset();
        call = 1'b1;
        tick();
        call     = 1'b0;
        hold     = 1'b1;
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        checks++; if (pc !== RST_A || pc_valid !== 1'b0 || ras_empty !== 1'b1) begin
            errors++; $display("FAIL soft_rst: got pc=%h valid=%b empty=%b expected %h/0/1", pc, pc_valid, ras_empty, RST_A);
        end
        tick();
        checks++; if (pc !== RST_A || pc_valid !== 1'b1) begin
            errors++; $display("FAIL soft_boot: got pc=%h valid=%b expected %h/1", pc, pc_valid, RST_A);
        end
        hold = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            soft_rst       = ($urandom_range(0, 39) == 0);
            redir_valid[0] = ($urandom_range(0, 9) == 0);
            redir_valid[1] = ($urandom_range(0, 9) == 0);
            redir_addr[0]  = $urandom;
            redir_addr[1]  = $urandom;
            hold           = ($urandom_range(0, 3) == 0);
            fetch_ready    = ($urandom_range(0, 3) != 0);
            step2          = $urandom_range(0, 1) == 1;
            call           = ($urandom_range(0, 3) == 0);
            ret            = ($urandom_range(0, 3) == 0);
            tick();
            checks++; if (pc !== m_pc || pc_valid !== m_valid) begin
                errors++; $display("FAIL rand_pc_%0d: got pc=%h valid=%b expected pc=%h valid=%b", n, pc, pc_valid, m_pc, m_valid);
            end
            checks++; if (redir_taken !== m_taken || ras_miss !== m_miss || ras_empty !== m_empty()) begin
                errors++; $display("FAIL rand_flags_%0d: got taken=%b miss=%b empty=%b expected %b/%b/%b",
                                   n, redir_taken, ras_miss, ras_empty, m_taken, m_miss, m_empty());
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        redirect_to(32'h700);
        call          = 1'b1;
        redir_valid   = 2'b01;
        redir_addr[0] = 32'h500;
        tick();
        #3 rst = 1'b1;
        #1;
        checks++; if (pc !== RST_A || pc_valid !== 1'b0 || ras_empty !== 1'b1 || redir_taken !== 1'b0) begin
            errors++; $display("FAIL async_rst: got pc=%h valid=%b empty=%b taken=%b expected %h/0/1/0",
                               pc, pc_valid, ras_empty, redir_taken, RST_A);
        end
        @(posedge clk);
        #1;
        checks++; if (pc !== RST_A || redir_taken !== 1'b0) begin
            errors++; $display("FAIL async_rst_hold: got pc=%h taken=%b expected %h/0", pc, redir_taken, RST_A);
        end
        idle_inputs();
        model_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (pc !== 32'h104 || ras_empty !== 1'b1) begin
            errors++; $display("FAIL async_rst_resume: got pc=%h empty=%b expected 00000104/1", pc, ras_empty);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_step();
        test_ras_call_ret();
        test_ras_overflow();
        test_soft_reset();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: PC and target width.
REQ-002 SHALL have parameter RESET_ADDR, default 'h0: PC value after reset.
REQ-003 SHALL have parameter NUM_REDIR, default 2, range 1..8: number of redirect channels.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, power of two, at least 2: return-address-stack entries.
REQ-005 SHALL have ports: clk_i in 1, single clock; rst_i in 1, asynchronous active-high reset.
REQ-006 SHALL have soft_rst_i in 1: synchronous debug/JTAG reset request.
REQ-007 SHALL have redir_valid_i in NUM_REDIR and redir_addr_i in NUM_REDIR x ADDR_W: redirect requests; index 0 has highest priority.
REQ-008 SHALL have hold_i in 1: pipeline stall.
REQ-009 SHALL have fetch_ready_i in 1: fetch accepts pc_o.
REQ-010 SHALL have step2_i in 1: current instruction is compressed (step 2, else 4).
REQ-011 SHALL have call_i in 1 and ret_i in 1: current fetch is a call / return hint.
REQ-012 SHALL have pc_o out ADDR_W, pc_valid_o out 1, redir_taken_o out 1 (one-cycle pulse), ras_empty_o out 1, ras_miss_o out 1 (one-cycle pulse).

Function
REQ-013 SHALL implement FSM BOOT -> RUN; BOOT lasts exactly one cycle after rst_i deasserts, with pc_valid_o=0; RUN sets pc_valid_o=1.
REQ-014 SHALL define "advance" as RUN & pc_valid_o & fetch_ready_i & !hold_i.
REQ-015 SHALL select next pc_o by priority: soft_rst_i -> RESET_ADDR; lowest-index valid redirect -> its address; advance & ret_i & !ras_empty_o -> RAS top; advance -> pc_o + (step2_i ? 2 : 4); otherwise hold.
REQ-016 SHALL take redirects in any state or cycle, independent of hold_i and fetch_ready_i; the new PC appears on pc_o the next cycle.
REQ-017 SHALL force bit 0 of every loaded target to 0.
REQ-018 SHALL compute increments modulo 2^ADDR_W; all-ones minus 3 plus 4 wraps to 0.
REQ-019 SHALL assert redir_taken_o the cycle after any redirect is accepted.
REQ-020 SHALL, on soft_rst_i, re-enter BOOT for one cycle (pc_valid_o=0) and clear the RAS.

Reset
REQ-021 SHALL, on rst_i assertion, immediately set pc_o=RESET_ADDR, pc_valid_o=0, state BOOT, RAS count 0, ras_empty_o=1, redir_taken_o=0, ras_miss_o=0.
REQ-022 SHALL, on rst_i assertion mid-operation, discard pending push/pop and redirect effects.

Configuration
REQ-023 SHALL, with macro PC_GEN_RAS_EN defined, push on advance & call_i (value pc_o + step) and pop on advance & ret_i & non-empty.
REQ-024 SHALL, on call_i & ret_i together, replace the top entry (pop then push); count is unchanged when non-empty.
REQ-025 SHALL, on a push when full, overwrite the oldest entry circularly; count saturates at RAS_DEPTH.
REQ-026 SHALL, on ret_i when empty, increment sequentially and pulse ras_miss_o.
REQ-027 SHALL leave the RAS unchanged when a redirect and a push/pop occur in the same cycle.
REQ-028 SHALL, without PC_GEN_RAS_EN, keep the ports but ignore call_i/ret_i, drive ras_empty_o=1 and ras_miss_o=0, and instantiate no RAS storage.

Structure
REQ-029 SHALL place the FSM state enum, step constants (2, 4) and the default RESET_ADDR in the shared core package.
REQ-030 SHALL implement the RAS as sub-module pc_ras (pointer, count, storage), instantiated only under PC_GEN_RAS_EN.

Verification
REQ-031 SHALL verify: RESET_ADDR='h100; release rst_i -> one cycle pc_valid_o=0, then pc_o 'h100, 'h104, 'h108 with fetch_ready_i=1.
REQ-032 SHALL verify: redir_valid_i=2'b11, addresses 'h200/'h300, hold_i=1 -> next pc_o='h200 and redir_taken_o pulse.
REQ-033 SHALL verify: step2_i=1 from pc 'h10 -> 'h12; pc 'hFFFF_FFFC with step 4 -> 'h0.
REQ-034 SHALL verify: call_i at pc 'h40, redirect to 'h80, ret_i at 'h80 -> pc_o 'h44 and ras_empty_o=1.
REQ-035 SHALL verify: RAS_DEPTH+1 calls, then RAS_DEPTH+1 returns -> the last return increments sequentially and pulses ras_miss_o.
REQ-036 SHALL verify: soft_rst_i during hold -> pc_o=RESET_ADDR, one BOOT cycle, RAS emptied.
